// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared types, constants and helpers for the 4-digit 7-segment display path.
//   - conv_state_t : double-dabble converter states
//   - SEG_*        : active-low segment patterns {dp,g,f,e,d,c,b,a}, dp off
//   - COM_D*       : active-low one-hot anode patterns, D0 = ones digit
//   - seg_encode   : BCD nibble -> segment pattern (10..15 blank)
//   - com_encode   : digit index -> anode pattern
//   - dabble_adjust: add 3 to every BCD nibble >= 5
// -----------------------------------------------------------------------------
package fnd_pkg;

  localparam int BIN_W = 14;
  localparam int BCD_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  localparam logic [3:0] COM_D0 = 4'b1110;
  localparam logic [3:0] COM_D1 = 4'b1101;
  localparam logic [3:0] COM_D2 = 4'b1011;
  localparam logic [3:0] COM_D3 = 4'b0111;

  function automatic logic [7:0] seg_encode(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  function automatic logic [3:0] com_encode(input logic [1:0] idx);
    logic [3:0] com;
    case (idx)
      2'd0:    com = COM_D0;
      2'd1:    com = COM_D1;
      2'd2:    com = COM_D2;
      2'd3:    com = COM_D3;
      default: com = COM_D0;
    endcase
    return com;
  endfunction

  // A nibble >= 5 would exceed 9 after the following doubling, so pre-add 3.
  function automatic logic [BCD_W-1:0] dabble_adjust(input logic [BCD_W-1:0] bcd);
    logic [BCD_W-1:0] res;
    res = bcd;
    for (int i = 0; i < BCD_W / 4; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) begin
        res[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
      end else begin
        res[i*4 +: 4] = bcd[i*4 +: 4];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fnd_if.sv
// -----------------------------------------------------------------------------
// fnd_if
// Bundles the counter input and the display/debug outputs of fnd_controller.
//   i_count    : 14-bit binary count from the counter stage
//   o_fnd_com  : 4-bit active-low anodes, bit0 = ones digit
//   o_fnd_data : 8-bit active-low segments {dp,g,f,e,d,c,b,a}
//   o_bcd      : 16-bit registered BCD {thousands,hundreds,tens,ones}
// master = upstream/board side, slave = fnd_controller.
// -----------------------------------------------------------------------------
interface fnd_if;
  import fnd_pkg::*;

  logic [BIN_W-1:0] i_count;
  logic [3:0]       o_fnd_com;
  logic [7:0]       o_fnd_data;
  logic [BCD_W-1:0] o_bcd;

  modport master (
    output i_count,
    input  o_fnd_com,
    input  o_fnd_data,
    input  o_bcd
  );

  modport slave (
    input  i_count,
    output o_fnd_com,
    output o_fnd_data,
    output o_bcd
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// -----------------------------------------------------------------------------
// bin2bcd_seq
// Free-running sequential double-dabble converter. IDLE samples and saturates
// i_bin, SHIFT performs 14 adjust+shift steps, DONE publishes the result.
// One conversion every 16 clocks; input changes during SHIFT are ignored.
// Ports:
//   clk   : system clock, rising edge
//   rst   : synchronous active-high reset
//   i_bin : 14-bit binary input
//   o_bcd : 16-bit registered BCD result
// -----------------------------------------------------------------------------
module bin2bcd_seq
  import fnd_pkg::*;
#(
  parameter int COUNT_MAX = 9999
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BIN_W-1:0] i_bin,
  output logic [BCD_W-1:0] o_bcd
);

  localparam logic [BIN_W-1:0] SAT_MAX = BIN_W'(COUNT_MAX);

  conv_state_t      state_r, state_s;
  logic [BIN_W-1:0] bin_r, bin_s;
  logic [BCD_W-1:0] scr_r, scr_s;
  logic [3:0]       cnt_r, cnt_s;
  logic [BCD_W-1:0] bcd_r, bcd_s;
  logic [BCD_W-1:0] adj_s;

  // Next-state and datapath for the converter FSM.
  always_comb begin
    state_s = state_r;
    bin_s   = bin_r;
    scr_s   = scr_r;
    cnt_s   = cnt_r;
    bcd_s   = bcd_r;
    adj_s   = dabble_adjust(scr_r);
    case (state_r)
      IDLE: begin
        if (i_bin > SAT_MAX) begin
          bin_s = SAT_MAX;
        end else begin
          bin_s = i_bin;
        end
        scr_s   = 16'h0000;
        cnt_s   = 4'd14;
        state_s = SHIFT;
      end
      SHIFT: begin
        // {scratch,bin} << 1 after the nibble adjust
        scr_s = {adj_s[BCD_W-2:0], bin_r[BIN_W-1]};
        bin_s = {bin_r[BIN_W-2:0], 1'b0};
        cnt_s = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        bcd_s   = scr_r;
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Converter state and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      bin_r   <= 14'd0;
      scr_r   <= 16'h0000;
      cnt_r   <= 4'd0;
      bcd_r   <= 16'h0000;
    end else begin
      state_r <= state_s;
      bin_r   <= bin_s;
      scr_r   <= scr_s;
      cnt_r   <= cnt_s;
      bcd_r   <= bcd_s;
    end
  end

  assign o_bcd = bcd_r;

endmodule

// File: rtl/fnd_controller.sv
// -----------------------------------------------------------------------------
// fnd_controller
// Converts a 14-bit count to BCD (bin2bcd_seq) and time-multiplexes the four
// digits onto a common-anode 7-segment display.
// Ports:
//   clk     : system clock, rising edge
//   rst     : synchronous active-high reset
//   fnd_bus : fnd_if.slave (i_count in; o_fnd_com, o_fnd_data, o_bcd out)
// Parameters: SYS_CLK_HZ, SCAN_HZ (SYS_CLK_HZ/SCAN_HZ >= 2), COUNT_MAX.
// Optional: define FND_LZB_EN for leading-zero blanking of digits 3..1.
// -----------------------------------------------------------------------------
module fnd_controller
  import fnd_pkg::*;
#(
  parameter int SYS_CLK_HZ = 100_000_000,
  parameter int SCAN_HZ    = 1000,
  parameter int COUNT_MAX  = 9999
) (
  input  logic clk,
  input  logic rst,
  fnd_if.slave fnd_bus
);

  localparam int              SCAN_DIV = SYS_CLK_HZ / SCAN_HZ;
  localparam int              PRE_W    = $clog2(SCAN_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

  logic [BCD_W-1:0] bcd_s;
  logic [PRE_W-1:0] pre_r;
  logic [1:0]       idx_r;
  logic             tick_s;
  logic [3:0]       nib_s;
  logic             blank_s;
  logic [7:0]       data_s;
  logic [3:0]       com_s;
  logic [3:0]       com_r;
  logic [7:0]       data_r;

  bin2bcd_seq #(
    .COUNT_MAX (COUNT_MAX)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .i_bin (fnd_bus.i_count),
    .o_bcd (bcd_s)
  );

  assign tick_s = (pre_r == PRE_LAST);

  // Scan prescaler and digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_r <= {PRE_W{1'b0}};
      idx_r <= 2'd0;
    end else if (tick_s) begin
      pre_r <= {PRE_W{1'b0}};
      idx_r <= idx_r + 2'd1;
    end else begin
      pre_r <= pre_r + {{(PRE_W-1){1'b0}}, 1'b1};
      idx_r <= idx_r;
    end
  end

  // Digit select, optional blanking and segment/anode decode.
  always_comb begin
    nib_s   = 4'd0;
    blank_s = 1'b0;
    case (idx_r)
      2'd0:    nib_s = bcd_s[3:0];
      2'd1:    nib_s = bcd_s[7:4];
      2'd2:    nib_s = bcd_s[11:8];
      2'd3:    nib_s = bcd_s[15:12];
      default: nib_s = 4'd0;
    endcase
`ifdef FND_LZB_EN
    // A digit is blank when it and every more-significant digit are zero.
    case (idx_r)
      2'd1:    blank_s = (bcd_s[15:4]  == 12'h000);
      2'd2:    blank_s = (bcd_s[15:8]  == 8'h00);
      2'd3:    blank_s = (bcd_s[15:12] == 4'h0);
      default: blank_s = 1'b0;
    endcase
`else
    blank_s = 1'b0;
`endif
    if (blank_s) begin
      data_s = SEG_BLANK;
    end else begin
      data_s = seg_encode(nib_s);
    end
    com_s = com_encode(idx_r);
  end

  // Anode and segment outputs, registered together so they never mix digits.
  always_ff @(posedge clk) begin
    if (rst) begin
      com_r  <= COM_D0;
      data_r <= SEG_0;
    end else begin
      com_r  <= com_s;
      data_r <= data_s;
    end
  end

  assign fnd_bus.o_fnd_com  = com_r;
  assign fnd_bus.o_fnd_data = data_r;
  assign fnd_bus.o_bcd      = bcd_s;

endmodule

// File: tb/tb_fnd_controller.sv
// Self-checking bench for fnd_controller (SYS_CLK_HZ=1000, SCAN_HZ=250 -> a
// scan tick every 4 clocks). Expected values come from decimal arithmetic on
// the saturated count, not from any model of the converter's internals.
module tb_fnd_controller;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  fnd_if bus ();

  fnd_controller #(
    .SYS_CLK_HZ (1000),
    .SCAN_HZ    (250),
    .COUNT_MAX  (9999)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .fnd_bus (bus)
  );

  localparam logic [7:0] SEG_TAB [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                                         8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 9999) ? 9999 : v;
  endfunction

  function automatic int pow10(input int k);
    int p = 1;
    for (int i = 0; i < k; i++) p = p * 10;
    return p;
  endfunction

  function automatic logic [15:0] model_bcd(input int v);
    int s = sat(v);
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  function automatic logic [7:0] model_data(input int v, input int idx);
    int s = sat(v);
`ifdef FND_LZB_EN
    if (idx > 0 && s < pow10(idx)) return 8'hFF;
`endif
    return SEG_TAB[(s / pow10(idx)) % 10];
  endfunction

  task automatic set_count(input int v);
    @(negedge clk);
    bus.i_count = 14'(v);
  endtask

  // Poll up to 32 clocks for the expected BCD, then compare.
  task automatic wait_bcd(input int v, input string tag);
    logic [15:0] e = model_bcd(v);
    for (int i = 0; i < 32; i++) begin
      @(posedge clk);
      #1;
      if (bus.o_bcd === e) break;
    end
    check_eq(tag, 32'(bus.o_bcd), 32'(e));
  endtask

  // Watch the multiplexed outputs: valid one-hot anode, matching segments,
  // 4 clocks per digit, index order 0,1,2,3,0...
  task automatic scan_check(input int v, input int cycles, input string tag);
    int prev = -1;
    int run = 0;
    int n_chg = 0;
    int idx;
    logic [3:0] com;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      com = bus.o_fnd_com;
      case (com)
        4'b1110: idx = 0;
        4'b1101: idx = 1;
        4'b1011: idx = 2;
        4'b0111: idx = 3;
        default: idx = -1;
      endcase
      check_eq({tag, "_com_valid"}, 32'(idx >= 0), 32'd1);
      if (idx >= 0) begin
        check_eq({tag, "_data"}, 32'(bus.o_fnd_data), 32'(model_data(v, idx)));
        if (idx != prev) begin
          if (prev >= 0) begin
            check_eq({tag, "_order"}, 32'(idx), 32'((prev + 1) % 4));
            if (n_chg >= 1) check_eq({tag, "_dwell"}, 32'(run), 32'd4);
            n_chg++;
          end
          prev = idx;
          run = 1;
        end else begin
          run++;
        end
      end
    end
    check_eq({tag, "_advances"}, 32'(n_chg >= 5), 32'd1);
  endtask

  initial begin
    int vals[10] = '{0, 9, 10, 99, 100, 999, 1000, 9999, 16383, 10000};
    int v;
    int first_seen;
    int bad;

    // Reset behaviour
    rst = 1'b1;
    bus.i_count = 14'd1234;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_bcd", 32'(bus.o_bcd), 32'h0000);
    check_eq("rst_com", 32'(bus.o_fnd_com), 32'hE);
    check_eq("rst_data", 32'(bus.o_fnd_data), 32'hC0);
    rst = 1'b0;
    wait_bcd(1234, "rst_release_bcd");

    // Directed sweep including saturation
    foreach (vals[i]) begin
      set_count(vals[i]);
      wait_bcd(vals[i], $sformatf("sweep_%0d", vals[i]));
    end

    // Random values across the full 14-bit range and the displayable range
    for (int i = 0; i < 12; i++) begin
      if (i % 2 == 0) v = int'($urandom_range(0, 16383));
      else            v = int'($urandom_range(0, 9999));
      set_count(v);
      wait_bcd(v, $sformatf("rand_%0d", v));
    end

    // Scan / segment checks
    set_count(5678);
    wait_bcd(5678, "scan5678_bcd");
    repeat (2) @(posedge clk);
    scan_check(5678, 24, "scan5678");

    set_count(7);
    wait_bcd(7, "scan7_bcd");
    repeat (2) @(posedge clk);
    scan_check(7, 20, "scan7");

    set_count(0);
    wait_bcd(0, "scan0_bcd");
    repeat (2) @(posedge clk);
    scan_check(0, 20, "scan0");

    v = int'($urandom_range(0, 9999));
    set_count(v);
    wait_bcd(v, "scanrand_bcd");
    repeat (2) @(posedge clk);
    scan_check(v, 20, "scanrand");

    // Mid-conversion change: 2222 arrives 5 cycles into a 1111 conversion.
    set_count(1111);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.o_bcd === 16'h1111) break;
    end
    check_eq("midconv_first", 32'(bus.o_bcd), 32'h1111);
    repeat (5) @(posedge clk);
    @(negedge clk);
    bus.i_count = 14'd2222;
    first_seen = -1;
    bad = 0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (bus.o_bcd !== 16'h1111 && bus.o_bcd !== 16'h2222) bad++;
      if (bus.o_bcd === 16'h2222 && first_seen < 0) first_seen = k;
    end
    check_eq("midconv_no_intermediate", 32'(bad), 32'd0);
    check_eq("midconv_latency", 32'(first_seen), 32'd27);

    // Reset in the middle of a conversion and scan
    set_count(4321);
    wait_bcd(4321, "midrst_pre_bcd");
    repeat (7) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_eq("midrst_bcd", 32'(bus.o_bcd), 32'h0000);
    check_eq("midrst_com", 32'(bus.o_fnd_com), 32'hE);
    check_eq("midrst_data", 32'(bus.o_fnd_data), 32'hC0);
    @(negedge clk);
    rst = 1'b0;
    wait_bcd(4321, "midrst_post_bcd");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
